// File: rtl/roi_pkg.sv
// Shared constants, FSM state type and counter-width helper for the pixel
// framing front end of the ROI pipeline.
package roi_pkg;

    localparam int DEF_PIXEL_SIZE = 8;
    localparam int DEF_WIDTH      = 1920;
    localparam int DEF_HEIGHT     = 1080;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } framer_state_t;

    // Counter width for a 0..n-1 range; a range of one still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer with a registered upstream ready that
// drops only when both entries are occupied.
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Storage is cleared as well so tdata/tlast read back as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            s_ready <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/pixel_framer.sv
// Frames a raw pixel stream into lines (tlast) and frames (done/err pulses).
// Optional PIXEL_FRAMER_SOF_EN adds o_m_axis_tuser on the (0,0) pixel.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for tuser; untagged pixels are accepted and dropped
// ST_ACTIVE | inside a frame; every accepted pixel is forwarded
module pixel_framer
    import roi_pkg::*;
#(
    parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIXEL_SIZE-1:0] i_s_axis_tdata,
    input  logic                  i_s_axis_tvalid,
    input  logic                  i_s_axis_tuser,
    output logic                  o_s_axis_tready,
    output logic [PIXEL_SIZE-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    output logic                  o_m_axis_tlast,
`ifdef PIXEL_FRAMER_SOF_EN
    output logic                  o_m_axis_tuser,
`endif
    input  logic                  i_m_axis_tready,
    output logic                  o_frame_done,
    output logic                  o_frame_err
);

    localparam int COL_W = cnt_width(WIDTH);
    localparam int ROW_W = cnt_width(HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
`ifdef PIXEL_FRAMER_SOF_EN
    localparam int SKID_W = PIXEL_SIZE + 2;
`else
    localparam int SKID_W = PIXEL_SIZE + 1;
`endif

    framer_state_t     state;
    framer_state_t     state_next;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_next;
    logic [COL_W-1:0]  pos_col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_next;
    logic [ROW_W-1:0]  pos_row;
    logic              done_next;
    logic              err_next;
    logic              in_xfer;
    logic              forward;
    logic              pix_last;
    logic              frame_end;

    logic              skid_in_ready;
    logic [SKID_W-1:0] skid_in_data;
    logic [SKID_W-1:0] skid_out_data;

    assign in_xfer         = i_s_axis_tvalid & skid_in_ready;
    assign o_s_axis_tready = skid_in_ready;

    // A tagged pixel always restarts at (0,0), whatever the counters say.
    assign pos_col   = i_s_axis_tuser ? '0 : col;
    assign pos_row   = i_s_axis_tuser ? '0 : row;
    assign pix_last  = (pos_col == COL_LAST);
    assign frame_end = pix_last && (pos_row == ROW_LAST);

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        done_next  = 1'b0;
        err_next   = o_frame_err;
        forward    = 1'b0;

        if (in_xfer) begin
            if (state == ST_IDLE) begin
                forward = i_s_axis_tuser;
            end else begin
                forward = 1'b1;
                if (i_s_axis_tuser && ((col != '0) || (row != '0))) begin
                    err_next = 1'b1;
                end
            end
        end

        if (forward) begin
            if (frame_end) begin
                col_next   = '0;
                row_next   = '0;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end else if (pix_last) begin
                col_next   = '0;
                row_next   = pos_row + 1'b1;
                state_next = ST_ACTIVE;
            end else begin
                col_next   = pos_col + 1'b1;
                row_next   = pos_row;
                state_next = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_next;
            col          <= col_next;
            row          <= row_next;
            o_frame_done <= done_next;
            o_frame_err  <= err_next;
        end
    end

`ifdef PIXEL_FRAMER_SOF_EN
    assign skid_in_data   = {(pos_col == '0) && (pos_row == '0), pix_last, i_s_axis_tdata};
    assign o_m_axis_tuser = skid_out_data[PIXEL_SIZE+1];
`else
    assign skid_in_data   = {pix_last, i_s_axis_tdata};
`endif
    assign o_m_axis_tdata = skid_out_data[PIXEL_SIZE-1:0];
    assign o_m_axis_tlast = skid_out_data[PIXEL_SIZE];

    axis_skid_buffer #(
        .DATA_W (SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (skid_in_data),
        .s_valid (forward),
        .s_ready (skid_in_ready),
        .m_data  (skid_out_data),
        .m_valid (o_m_axis_tvalid),
        .m_ready (i_m_axis_tready)
    );

endmodule

// File: tb/tb_pixel_framer.sv
// Randomised and directed bench for pixel_framer (4x3 frames) against a
// frame-index reference model; define PIXEL_FRAMER_SOF_EN to cover tuser out.
module tb_pixel_framer;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       s;
    } px_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tuser = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tuser;
    logic       m_tready = 1'b1;
    logic       frame_done;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    pixel_framer #(.PIXEL_SIZE(8), .WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_s_axis_tdata  (s_tdata),
        .i_s_axis_tvalid (s_tvalid),
        .i_s_axis_tuser  (s_tuser),
        .o_s_axis_tready (s_tready),
        .o_m_axis_tdata  (m_tdata),
        .o_m_axis_tvalid (m_tvalid),
        .o_m_axis_tlast  (m_tlast),
`ifdef PIXEL_FRAMER_SOF_EN
        .o_m_axis_tuser  (m_tuser),
`endif
        .i_m_axis_tready (m_tready),
        .o_frame_done    (frame_done),
        .o_frame_err     (frame_err)
    );

`ifndef PIXEL_FRAMER_SOF_EN
    assign m_tuser = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    px_t exp_q[$];
    px_t obs[$];
    bit  in_frame = 0;
    int  k = 0;
    bit  err_m = 0;
    bit  done_exp = 0;
    bit  started = 0;
    bit  just_reset = 0;
    int  done_cnt = 0;
    int  rdy_low_cnt = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_d;
    logic prev_l;

    always @(negedge clk) begin
        px_t e;
        px_t o;
        if (!started) begin
            if (rst_n === 1'b0) begin
                started    = 1;
                just_reset = 1;
            end
        end else begin
            chk("frame_done", frame_done, done_exp);
            chk("frame_err", frame_err, err_m);
            chk("s_tready", s_tready, just_reset ? 1'b0 : (exp_q.size() < 2));
            chk("m_tvalid", m_tvalid, exp_q.size() != 0);
            if (just_reset) chk("tlast_after_reset", m_tlast, 1'b0);
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, prev_d);
                chk("stall_last", m_tlast, prev_l);
            end
            if (frame_done === 1'b1) done_cnt++;
            if (s_tready === 1'b0 && !just_reset) rdy_low_cnt++;
            done_exp   = 0;
            prev_stall = 0;
            if (rst_n === 1'b0) begin
                exp_q.delete();
                in_frame   = 0;
                k          = 0;
                err_m      = 0;
                just_reset = 1;
            end else begin
                just_reset = 0;
                if (m_tvalid && !m_tready) begin
                    prev_stall = 1;
                    prev_d     = m_tdata;
                    prev_l     = m_tlast;
                end
                if (m_tvalid && m_tready) begin
                    o.d = m_tdata;
                    o.l = m_tlast;
                    o.s = m_tuser;
                    obs.push_back(o);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_tdata, e.d);
                        chk("out_last", m_tlast, e.l);
`ifdef PIXEL_FRAMER_SOF_EN
                        chk("out_sof", m_tuser, e.s);
`endif
                    end
                end
                if (s_tvalid && s_tready) begin
                    if (s_tuser) begin
                        if (in_frame && k != 0) err_m = 1;
                        k        = 0;
                        in_frame = 1;
                    end
                    if (in_frame) begin
                        e.d = s_tdata;
                        e.l = ((k % W) == W - 1);
                        e.s = (k == 0);
                        exp_q.push_back(e);
                        k++;
                        if (k == W * H) begin
                            in_frame = 0;
                            k        = 0;
                            done_exp = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- downstream ready ----------------
    int   rdy_mode = 0;
    int   ph = 0;
    logic [3:0] pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                m_tready = pat[3 - ph];
                ph = (ph + 1) % 4;
            end
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b1;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_px(input logic [7:0] d, input logic u);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_bound", n < 200, 1'b1);
        idle(2);
    endtask

    task automatic clear_obs();
        obs.delete();
        done_cnt = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int junk;
        int rs;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_reset", s_tready, 1'b1);

        // plain frame, ready held high
        clear_obs();
        for (int i = 0; i < W * H; i++) send_px(8'(i), i == 0);
        drain();
        chk("t1_count", obs.size(), 12);
        for (int i = 0; i < obs.size(); i++) begin
            chk("t1_data", obs[i].d, 8'(i));
            chk("t1_last", obs[i].l, (i == 3) || (i == 7) || (i == 11));
        end
        chk("t1_done_cnt", done_cnt, 1);

        // untagged pixels in IDLE are dropped
        clear_obs();
        send_px(8'hA0, 1'b0);
        send_px(8'hA1, 1'b0);
        for (int i = 0; i < W * H; i++) send_px(8'(8'h10 + i), i == 0);
        drain();
        chk("t2_count", obs.size(), 12);
        if (obs.size() > 0) chk("t2_first", obs[0].d, 8'h10);

        // backpressure 1,0,0,1
        clear_obs();
        rdy_low_cnt = 0;
        rdy_mode    = 1;
        for (int i = 0; i < W * H; i++) send_px(8'(8'h20 + i), i == 0);
        drain();
        rdy_mode = 0;
        chk("t3_count", obs.size(), 12);
        for (int i = 0; i < obs.size(); i++) chk("t3_data", obs[i].d, 8'(8'h20 + i));
        chk("t3_backpressure_seen", rdy_low_cnt > 0, 1'b1);

        // tuser on the 6th pixel truncates the frame
        clear_obs();
        for (int i = 0; i < 5; i++) send_px(8'(8'h30 + i), i == 0);
        for (int i = 0; i < W * H; i++) send_px(8'(8'h35 + i), i == 0);
        drain();
        chk("t4_err", frame_err, 1'b1);
        chk("t4_count", obs.size(), 17);
        if (obs.size() == 17) begin
            chk("t4_restart_px", obs[5].d, 8'h35);
            chk("t4_last3", obs[3].l, 1'b1);
            chk("t4_last4", obs[4].l, 1'b0);
            chk("t4_last7", obs[7].l, 1'b0);
            chk("t4_last8", obs[8].l, 1'b1);
            chk("t4_last16", obs[16].l, 1'b1);
`ifdef PIXEL_FRAMER_SOF_EN
            chk("t4_sof0", obs[0].s, 1'b1);
            chk("t4_sof5", obs[5].s, 1'b1);
            chk("t4_sof6", obs[6].s, 1'b0);
`endif
        end
        chk("t4_done_cnt", done_cnt, 1);
        for (int i = 0; i < W * H; i++) send_px(8'(8'h60 + i), i == 0);
        drain();
        chk("t4_err_sticky", frame_err, 1'b1);

        // one-cycle reset mid-line with data in the skid
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) send_px(8'(8'h40 + i), i == 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t5_tvalid", m_tvalid, 1'b0);
        chk("t5_tlast", m_tlast, 1'b0);
        chk("t5_done", frame_done, 1'b0);
        chk("t5_err", frame_err, 1'b0);
        chk("t5_tready", s_tready, 1'b0);
        idle(1);
        chk("t5_tready_back", s_tready, 1'b1);
        clear_obs();
        for (int i = 0; i < W * H; i++) send_px(8'(8'h50 + i), i == 0);
        drain();
        rdy_mode = 0;
        chk("t5_count", obs.size(), 12);
        for (int i = 0; i < obs.size(); i++) begin
            chk("t5_data", obs[i].d, 8'(8'h50 + i));
            chk("t5_last", obs[i].l, (i % W) == W - 1);
        end
        chk("t5_done_cnt", done_cnt, 1);

        // randomised frames with junk, restarts, gaps and random ready
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            junk = $urandom_range(0, 2);
            rs   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : -1;
            for (int j = 0; j < junk; j++) send_px(8'($urandom), 1'b0);
            for (int i = 0; i < W * H; i++) begin
                send_px(8'($urandom), (i == 0) || (i == rs));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        drain();
        rdy_mode = 0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_framer.md
PIXEL_FRAMER -- requirements
Module: pixel_framer

Interface
REQ-001 SHALL have parameter PIXEL_SIZE, default 8, meaning pixel data width in bits.
REQ-002 SHALL have parameter WIDTH, default 1920, meaning active pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 1080, meaning active lines per frame.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning synchronous, active-low reset.
REQ-006 SHALL have port i_s_axis_tdata  input  PIXEL_SIZE  meaning the raw pixel.
REQ-007 SHALL have port i_s_axis_tvalid  input  1  meaning the raw pixel is valid.
REQ-008 SHALL have port i_s_axis_tuser  input  1  meaning the start-of-frame marker on pixel (0,0).
REQ-009 SHALL have port o_s_axis_tready  output  1  meaning the block accepts a pixel.
REQ-010 SHALL have port o_m_axis_tdata  output  PIXEL_SIZE  meaning the framed pixel sent to the ROI stage.
REQ-011 SHALL have port o_m_axis_tvalid  output  1  meaning the output pixel is valid.
REQ-012 SHALL have port o_m_axis_tlast  output  1  meaning the last pixel of a line.
REQ-013 SHALL have port i_m_axis_tready  input  1  meaning the downstream ROI stage accepts.
REQ-014 SHALL have port o_frame_done  output  1  meaning a one-cycle pulse when the last pixel of a frame is accepted.
REQ-015 SHALL have port o_frame_err  output  1  meaning a sticky truncated-frame flag.

Function
REQ-016 SHALL treat an input transfer as occurring on i_s_axis_tvalid & o_s_axis_tready, and an output transfer as occurring on o_m_axis_tvalid & i_m_axis_tready.
REQ-017 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), each $clog2 of its parameter bits wide, advanced only on an input transfer.
REQ-018 SHALL implement FSM states IDLE and ACTIVE.
REQ-019 SHALL, in IDLE, discard transfers with tuser=0 (tready held high, nothing forwarded).
REQ-020 SHALL, on a transfer with tuser=1 in IDLE, forward the pixel as (0,0), set col=1 and row=0, and go to ACTIVE.
REQ-021 SHALL, in ACTIVE, forward every transfer.
REQ-022 SHALL wrap col to 0 at col=WIDTH-1 and increment row.
REQ-023 SHALL, on the transfer at (WIDTH-1, HEIGHT-1), pulse o_frame_done the next cycle, clear both counters, and return to IDLE.
REQ-024 SHALL drive o_m_axis_tlast=1 exactly on the pixel with col=WIDTH-1.
REQ-025 SHALL, on a transfer with tuser=1 in ACTIVE at a position other than (0,0), set o_frame_err, forward that pixel as the new (0,0), and restart the counters; no tlast is inserted for the truncated line.
REQ-026 SHALL give tuser=1 at exact position (0,0) in ACTIVE no special treatment.
REQ-027 SHALL have a latency of 1 cycle from input transfer to o_m_axis_tvalid when the output is idle.
REQ-028 SHALL sustain one pixel per cycle while i_m_axis_tready=1.
REQ-029 SHALL hold o_m_axis_tdata/tlast (and tuser) stable while tvalid=1 and tready=0.
REQ-030 SHALL drive o_s_axis_tready from a register, deasserting only when the 2-entry skid is full, so no pixel is lost under backpressure.
REQ-031 SHALL keep o_frame_err set until reset.

Reset
REQ-032 SHALL, with rst_n=0 at a clock edge, set the FSM to IDLE, col=row=0, clear the skid, o_m_axis_tvalid=0, o_m_axis_tlast=0, o_frame_done=0, o_frame_err=0, and o_s_axis_tready=0.
REQ-033 SHALL assert o_s_axis_tready=1 on the first cycle after rst_n returns high.
REQ-034 SHALL discard mid-frame pixels on reset; the block resynchronises on the next tuser.

Configuration
REQ-035 SHALL, with macro PIXEL_FRAMER_SOF_EN defined, add output o_m_axis_tuser (1 bit), high with the (0,0) pixel, carried through the skid alongside tdata.
REQ-036 SHALL, without PIXEL_FRAMER_SOF_EN, omit that port and its skid storage; all other behaviour is identical.

Structure
REQ-037 SHALL place default PIXEL_SIZE/WIDTH/HEIGHT constants, the FSM state typedef and the counter-width localparam functions in shared package roi_pkg.
REQ-038 SHALL implement the output buffering in one sub-module axis_skid_buffer (parameterised data width, 2 entries, registered tready).

Verification (bench uses WIDTH=4, HEIGHT=3)
REQ-039 SHALL check that 12 pixels 0x00..0x0B with tuser on 0x00 and ready=1 produce output 0x00..0x0B, tlast on 0x03/0x07/0x0B, and an o_frame_done pulse after 0x0B.
REQ-040 SHALL check that pixels 0xA0,0xA1 with tuser=0 in IDLE, followed by a frame, produce no output for 0xA0/0xA1.
REQ-041 SHALL check that a full frame under i_m_axis_tready toggling 1,0,0,1 loses and duplicates no pixel and that o_s_axis_tready drops only when the skid is full.
REQ-042 SHALL check that tuser on the 6th pixel of a frame sets o_frame_err, tags that pixel as (0,0), emits the next tlast 4 pixels later, and keeps o_frame_err high until reset.
REQ-043 SHALL check that rst_n=0 for 1 cycle mid-line clears all outputs per REQ-032 and that a following frame is framed correctly.
REQ-044 SHALL check that, with PIXEL_FRAMER_SOF_EN defined, o_m_axis_tuser is high only with the (0,0) pixel of each frame.
